// File: rtl/aes_pkg.sv
// Shared AES datapath types and the row-major-state to column-word helper.
package aes_pkg;

  typedef logic [127:0] state_t;
  typedef logic [31:0]  word_t;

  localparam int NB = 4;

  typedef enum logic {IDLE, DRAIN} unload_st_t;

  // Column c of a row-major state: s[0][c] lands in the top byte, s[3][c] in the bottom.
  function automatic word_t state_col(state_t s, logic [1:0] c);
    word_t w;
    w = '0;
    for (int r = 0; r < NB; r++) begin
      w[31-8*r -: 8] = s[127-8*(4*r+int'(c)) -: 8];
    end
    return w;
  endfunction

endpackage

// File: rtl/aes_state_unload.sv
// Serializes a completed row-major AES state into four column-major 32-bit beats.
module aes_state_unload
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_data,
  output logic         out_last
);

  // Valid/ready: a transfer happens on an edge where valid & ready are both high;
  // a producer holds valid and data stable until that edge. flush cancels both sides.
  unload_st_t st, st_nxt;
  logic [1:0] beat, beat_nxt;
  state_t     hold;
  logic       load;

  always_comb begin
    st_nxt   = st;
    beat_nxt = beat;
    load     = 1'b0;
    in_ready = 1'b0;
    case (st)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load     = 1'b1;
          beat_nxt = 2'd0;
          st_nxt   = DRAIN;
        end
      end
      DRAIN: begin
        if (out_ready) begin
          if (beat == 2'd3) begin
            // Last beat leaves: either refill immediately or go idle.
            in_ready = 1'b1;
            beat_nxt = 2'd0;
            if (in_valid) begin
              load = 1'b1;
            end else begin
              st_nxt = IDLE;
            end
          end else begin
            beat_nxt = beat + 2'd1;
          end
        end
      end
      default: st_nxt = IDLE;
    endcase
    if (flush) begin
      in_ready = 1'b0;
      load     = 1'b0;
      st_nxt   = IDLE;
      beat_nxt = 2'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st   <= IDLE;
      beat <= 2'd0;
      hold <= '0;
    end else begin
      st   <= st_nxt;
      beat <= beat_nxt;
      if (load) hold <= state_in;
    end
  end

  assign out_valid = (st == DRAIN);
  assign out_last  = out_valid & (beat == 2'd3);
  assign out_data  = out_valid ? state_col(hold, beat) : 32'd0;

endmodule
